system_top_entity_0: RTL and testbench

SYSTEM_TOP_ENTITY_0 -- requirements
Module: system_top_entity_0

---
 rtl/system_top_entity_0_pkg.sv | 62 ++++++
 rtl/system_program_rom.sv | 11 +
 rtl/system_top_entity_0.sv | 67 ++++++
 tb/tb_system_top_entity_0.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/system_top_entity_0_pkg.sv
// Shared types, widths and program image for the single-issue echo processor.
package system_top_entity_0_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned PC_W      = 5;
    localparam int unsigned ROM_DEPTH = 32;

    typedef enum logic [2:0] {
        OpLdi,
        OpAdd,
        OpSub,
        OpIn,
        OpOut,
        OpJmp,
        OpJnv,
        OpHalt
    } opcode_e;

    typedef struct packed {
        opcode_e             op;
        logic [1:0]          rd;
        logic [1:0]          ra;
        logic [1:0]          rb;
        logic [DATA_W-1:0]   imm;
        logic [PC_W-1:0]     addr;
    } instr_t;

    // Register operand r goes in both rd and ra so one helper serves IN and OUT.
    function automatic instr_t ins(opcode_e op, logic [1:0] r, logic [DATA_W-1:0] imm,
                                   logic [PC_W-1:0] addr);
        instr_t i;
        i.op   = op;
        i.rd   = r;
        i.ra   = r;
        i.rb   = 2'd0;
        i.imm  = imm;
        i.addr = addr;
        return i;
    endfunction

    localparam instr_t ROM [ROM_DEPTH] = '{
        ins(OpLdi, 2'd1, 16'h0048, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h0065, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h006C, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h006C, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h006F, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h0020, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h0057, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h006F, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h0072, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h006C, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h0064, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpLdi, 2'd1, 16'h0021, 5'd0), ins(OpOut, 2'd1, 16'h0000, 5'd0),
        ins(OpIn,  2'd2, 16'h0000, 5'd0),
        ins(OpJnv, 2'd0, 16'h0000, 5'd24),
        ins(OpOut, 2'd2, 16'h0000, 5'd0),
        ins(OpJmp, 2'd0, 16'h0000, 5'd24),
        ins(OpHalt, 2'd0, 16'h0000, 5'd0), ins(OpHalt, 2'd0, 16'h0000, 5'd0),
        ins(OpHalt, 2'd0, 16'h0000, 5'd0), ins(OpHalt, 2'd0, 16'h0000, 5'd0)
    };

endpackage

// File: rtl/system_program_rom.sv
// Combinational program ROM: returns the instruction record at the given PC.
module system_program_rom
    import system_top_entity_0_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    output instr_t          instr
);

    assign instr = ROM[pc];

endmodule

// File: rtl/system_top_entity_0.sv
// Single-issue processor: fetch from ROM, decode, 4-entry register file, V flag
// and registered 17-bit output port (bit 16 is a one-cycle valid strobe).
module system_top_entity_0
    import system_top_entity_0_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 5
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic [DATA_W:0]   eta_i1,
    output logic [DATA_W:0]   topLet_o
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic              v_q, v_d;
    logic [DATA_W:0]   out_q, out_d;
    instr_t            instr;

    system_program_rom u_rom (
        .pc    (pc_q),
        .instr (instr)
    );

    always_comb begin
        pc_d   = pc_q + PC_W'(1);
        regs_d = regs_q;
        v_d    = v_q;
        // Strobe drops every cycle; data holds the last value sent.
        out_d  = {1'b0, out_q[DATA_W-1:0]};
        case (instr.op)
            OpLdi:   regs_d[instr.rd] = instr.imm;
            OpAdd:   regs_d[instr.rd] = regs_q[instr.ra] + regs_q[instr.rb];
            OpSub:   regs_d[instr.rd] = regs_q[instr.ra] - regs_q[instr.rb];
            OpIn: begin
                regs_d[instr.rd] = eta_i1[DATA_W-1:0];
                v_d              = eta_i1[DATA_W];
            end
            OpOut:   out_d = {1'b1, regs_q[instr.ra]};
            OpJmp:   pc_d  = instr.addr;
            OpJnv: begin
                if (!v_q) pc_d = instr.addr;
            end
            OpHalt:  pc_d  = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            pc_q   <= '0;
            regs_q <= '{default: '0};
            v_q    <= 1'b0;
            out_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
            v_q    <= v_d;
            out_q  <= out_d;
        end
    end

    assign topLet_o = out_q;

endmodule

// File: tb/tb_system_top_entity_0.sv
// Directed bench for system_top_entity_0: message, echo loop, invalid input and resets.
module tb_system_top_entity_0;

    logic        clk;
    logic        rst;
    logic [16:0] eta;
    logic [16:0] out;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    system_top_entity_0 dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .eta_i1         (eta),
        .topLet_o       (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eta = 17'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_message();
        eta = 17'h0;
        for (int k = 1; k <= 24; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        eta = 17'h1FFFF;
        tick();
        tick();
        checks++;
        if (out !== 17'h00000) begin
            errors++;
            $display("FAIL reset_out: got %h want %h", out, 17'h00000);
        end
        checks++;
        if (dut.regs_q[2] !== 16'h0 || dut.v_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got R2=%h V=%b want R2=0000 V=0", dut.regs_q[2], dut.v_q);
        end
        rst = 1'b0;
        eta = 17'h0;
    endtask

    task automatic test_message();
        logic [16:0] exp;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k % 2 == 0) exp = {1'b1, 8'h00, msg[k/2-1]};
            else if (k == 1) exp = 17'h00000;
            else exp = {1'b0, 8'h00, msg[(k-1)/2-1]};
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL message_edge%0d: got %h want %h", k, out, exp);
            end
        end
        for (int k = 25; k <= 32; k++) begin
            tick();
            checks++;
            if (out !== 17'h00021) begin
                errors++;
                $display("FAIL post_message_edge%0d: got %h want %h", k, out, 17'h00021);
            end
        end
    endtask

    task automatic test_echo();
        logic [16:0] exp;
        logic [15:0] data;
        do_reset();
        run_message();
        eta = 17'h10041;
        for (int e = 25; e <= 40; e++) begin
            if (e == 29) eta = 17'h10042;
            tick();
            if (e < 27) data = 16'h0021;
            else if (e < 31) data = 16'h0041;
            else data = 16'h0042;
            exp = {(e >= 27 && ((e - 27) % 4 == 0)), data};
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL echo_edge%0d: got %h want %h", e, out, exp);
            end
        end
        eta = 17'h0;
    endtask

    task automatic test_max_value();
        do_reset();
        run_message();
        eta = 17'h1FFFF;
        tick();
        eta = 17'h0;
        tick();
        checks++;
        if (out !== 17'h00021) begin
            errors++;
            $display("FAIL max_edge26: got %h want %h", out, 17'h00021);
        end
        tick();
        checks++;
        if (out !== 17'h1FFFF) begin
            errors++;
            $display("FAIL max_edge27: got %h want %h", out, 17'h1FFFF);
        end
        for (int e = 28; e <= 32; e++) begin
            tick();
            checks++;
            if (out !== 17'h0FFFF) begin
                errors++;
                $display("FAIL max_hold_edge%0d: got %h want %h", e, out, 17'h0FFFF);
            end
        end
    endtask

    task automatic test_invalid();
        do_reset();
        run_message();
        eta = 17'h01234;
        for (int e = 25; e <= 36; e++) begin
            tick();
            checks++;
            if (out !== 17'h00021) begin
                errors++;
                $display("FAIL invalid_edge%0d: got %h want %h", e, out, 17'h00021);
            end
        end
        eta = 17'h0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 8; k++) tick();
        checks++;
        if (out !== 17'h1006C) begin
            errors++;
            $display("FAIL mid_fourth_char: got %h want %h", out, 17'h1006C);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out !== 17'h00000) begin
            errors++;
            $display("FAIL mid_reset_out: got %h want %h", out, 17'h00000);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (out !== 17'h00000) begin
            errors++;
            $display("FAIL mid_restart_edge1: got %h want %h", out, 17'h00000);
        end
        tick();
        checks++;
        if (out !== 17'h10048) begin
            errors++;
            $display("FAIL mid_restart_edge2: got %h want %h", out, 17'h10048);
        end
    endtask

    task automatic test_reset_during_in();
        do_reset();
        run_message();
        eta = 17'h10041;
        rst = 1'b1;
        tick();
        checks++;
        if (out !== 17'h00000) begin
            errors++;
            $display("FAIL rst_in_out: got %h want %h", out, 17'h00000);
        end
        checks++;
        if (dut.regs_q[2] !== 16'h0000) begin
            errors++;
            $display("FAIL rst_in_r2: got %h want %h", dut.regs_q[2], 16'h0000);
        end
        checks++;
        if (dut.v_q !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_v: got %b want %b", dut.v_q, 1'b0);
        end
        rst = 1'b0;
        eta = 17'h0;
        tick();
        tick();
        checks++;
        if (out !== 17'h10048) begin
            errors++;
            $display("FAIL rst_in_restart: got %h want %h", out, 17'h10048);
        end
    endtask

    initial begin
        rst = 1'b1;
        eta = 17'h0;
        test_reset();
        test_message();
        test_echo();
        test_max_value();
        test_invalid();
        test_reset_mid();
        test_reset_during_in();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
